friscv_m_issuer: RTL

FRISCV_M_ISSUER -- requirements
Module: friscv_m_issuer

---
 rtl/friscv_m_issuer_if.sv | 35 +++
 rtl/friscv_m_issuer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/friscv_m_issuer_if.sv
// friscv_m_issuer_if: decoder-side and M-extension-side instruction handshakes.
// Latency: none, this is only a bundle of wires.
// Backpressure: i_ready throttles the decoder and m_ready throttles the issuer.
//
// Signals:
//   i_valid / i_ready / i_instbus : instructions from the decoder into the issuer
//   m_valid / m_ready / m_instbus : instructions issued to the M-extension unit
// Modports:
//   slave  : the issuer's view (receives i_*, drives m_*)
//   master : the surrounding pipeline's view (drives i_*, receives m_*)

`ifndef INST_BUS_W
`define INST_BUS_W 80
`endif

interface friscv_m_issuer_if;

  logic                   i_valid;
  logic                   i_ready;
  logic [`INST_BUS_W-1:0] i_instbus;
  logic                   m_valid;
  logic                   m_ready;
  logic [`INST_BUS_W-1:0] m_instbus;

  modport slave (
    input  i_valid, i_instbus, m_ready,
    output i_ready, m_valid, m_instbus
  );

  modport master (
    output i_valid, i_instbus, m_ready,
    input  i_ready, m_valid, m_instbus
  );

endinterface

// File: rtl/friscv_m_issuer.sv
// friscv_m_issuer: buffers decoded M-extension instructions and issues them once operands are free.
// Latency: 1 cycle from push to earliest m_valid; 0 cycles with FRISCV_M_ISSUE_BYPASS_EN defined.
// Backpressure: i_ready = !full; m_valid/m_instbus hold until m_ready (flush drops m_valid).
//
// Ports:
//   aclk, aresetn      : clock, synchronous active-low reset
//   flush              : drop every buffered, not yet issued instruction
//   ibus (slave)       : i_valid/i_ready/i_instbus in, m_valid/m_ready/m_instbus out
//   m_regs_sts         : per-register status, 1 = no write pending
//   m_rd_wr            : one pulse per M-extension write-back
//   m_idle, outstanding: status (nothing buffered and nothing in flight / in-flight count)
// Optional feature macro: FRISCV_M_ISSUE_BYPASS_EN (same-cycle issue when the buffer is empty).

// Field layout of the instruction bus, matching friscv_h.sv.
`ifndef INST_BUS_W
`define INST_BUS_W 80
`endif
`ifndef FUNCT3
`define FUNCT3 9:7
`endif
`ifndef RS1
`define RS1 21:17
`endif
`ifndef RS2
`define RS2 26:22
`endif
`ifndef RD
`define RD 31:27
`endif

module friscv_m_issuer #(
  parameter int NB_INT_REG = 32,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int MAX_OUT    = 2
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       flush,
  friscv_m_issuer_if.slave           ibus,
  input  logic [NB_INT_REG-1:0]      m_regs_sts,
  input  logic                       m_rd_wr,
  output logic                       m_idle,
  output logic [$clog2(MAX_OUT):0]   outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;

  // Parameter sanity, evaluated at elaboration only.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("friscv_m_issuer: DEPTH must be a power of two and at least 2");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("friscv_m_issuer: XLEN must be 32 or 64");
  end

  logic [`INST_BUS_W-1:0] mem [DEPTH];
  logic [PW-1:0]          wptr;
  logic [PW-1:0]          rptr;
  logic [CW-1:0]          count;
  logic [OW-1:0]          out_cnt;

  logic                   empty;
  logic                   full;
  logic [`INST_BUS_W-1:0] head;
  logic [4:0]             head_rs1, head_rs2, head_rd;
  logic                   head_hz_ok;
  logic                   can_issue;
  logic                   push;
  logic                   pop;
  logic                   issue;
  logic                   rd_dec;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rptr];

  assign head_rs1   = head[`RS1];
  assign head_rs2   = head[`RS2];
  assign head_rd    = head[`RD];
  assign head_hz_ok = m_regs_sts[head_rs1] & m_regs_sts[head_rs2] & m_regs_sts[head_rd];

  // Gating with aresetn keeps every output at its idle value while reset is held.
  assign can_issue = aresetn & !flush & (out_cnt < OW'(MAX_OUT));

`ifdef FRISCV_M_ISSUE_BYPASS_EN
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       in_hz_ok;
  logic       bypass;

  assign in_rs1   = ibus.i_instbus[`RS1];
  assign in_rs2   = ibus.i_instbus[`RS2];
  assign in_rd    = ibus.i_instbus[`RD];
  assign in_hz_ok = m_regs_sts[in_rs1] & m_regs_sts[in_rs2] & m_regs_sts[in_rd];

  // An empty buffer lets the incoming instruction go straight to the unit.
  assign bypass         = empty & ibus.i_valid & in_hz_ok & can_issue;
  assign ibus.m_valid   = bypass | (!empty & head_hz_ok & can_issue);
  assign ibus.m_instbus = !aresetn ? '0 : (empty ? ibus.i_instbus : head);
  // A bypassed instruction taken this cycle never enters the buffer; one that
  // is refused is written and presented again from the head next cycle.
  assign push           = ibus.i_valid & ibus.i_ready & !flush & !(bypass & ibus.m_ready);
`else
  assign ibus.m_valid   = !empty & head_hz_ok & can_issue;
  assign ibus.m_instbus = aresetn ? head : '0;
  assign push           = ibus.i_valid & ibus.i_ready & !flush;
`endif

  // i_ready ignores a same-cycle pop to keep i_ready off the m_ready path.
  assign ibus.i_ready = aresetn & !full;

  assign issue  = ibus.m_valid & ibus.m_ready;
  assign pop    = issue & !empty;
  assign rd_dec = m_rd_wr & (out_cnt != '0);

  assign m_idle      = !aresetn | (empty & (out_cnt == '0));
  assign outstanding = aresetn ? out_cnt : '0;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wptr] <= ibus.i_instbus;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      out_cnt <= '0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      // Already-issued instructions still complete after a flush.
      case ({issue, rd_dec})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule
